uart_rx_parity_checker_seq: RTL and testbench
=============================================

# uart_rx_parity_checker_seq

Parametrised, sequential parity checker for the UART receive path. It accumulates parity serially as data bits are sampled, so it no longer needs the assembled parallel word. It then checks the received parity bit in one of four parity modes and reports a registered error pulse, a sticky error flag and an optional saturating error counter. It sits between the RX edge/bit sampler and the RX FSM; the FSM drives the frame and strobe inputs.

## Interface
- DATA_WIDTH, 8, data bits per frame (5..9 legal); sets the bit counter range.
- CNT_WIDTH, 8, width of the parity-error counter.
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- PAR_MODE  input  2  parity mode: 00 even, 01 odd, 10 mark (parity bit must be 1), 11 space (parity bit must be 0). Sampled at frame_start and held internally for the frame.
- frame_start  input  1  one-cycle pulse at the start bit; clears the accumulator and begins a frame.
- data_vld  input  1  one-cycle strobe: sampled_bit is a data bit.
- par_chk_en  input  1  one-cycle strobe: sampled_bit is the parity bit.
- sampled_bit  input  1  current sampled serial bit.
- err_clr  input  1  clears par_err_sticky and par_err_cnt.
- par_err  output  1  one-cycle registered error pulse.
- par_done  output  1  one-cycle pulse on every completed check, pass or fail.
- par_err_sticky  output  1  set on any error; held until err_clr.
- par_err_cnt  output  CNT_WIDTH  saturating error count; present only with PAR_ERR_CNT_EN.

## Operation
- FSM states: IDLE, DATA, WAIT_PAR.
- **IDLE**
  - frame_start: acc←0, bit_cnt←0, latch PAR_MODE, go to DATA.
  - data_vld and par_chk_en are ignored.
- **DATA**
  - data_vld: acc←acc^sampled_bit, bit_cnt←bit_cnt+1.
  - On the DATA_WIDTH-th data_vld, go to WAIT_PAR.
  - par_chk_en is ignored.
- **WAIT_PAR**
  - par_chk_en: compare sampled_bit with the expected bit, then return to IDLE.
  - Expected bit by mode: even → acc; odd → ~acc; mark → 1; space → 0.
  - data_vld is ignored.
- **Restart:** frame_start in any state restarts the frame (acc and bit_cnt cleared, mode re-latched, go to DATA). It takes priority over data_vld and par_chk_en in the same cycle.
- **Mismatch:** par_err=1 for one cycle, par_err_sticky←1, counter increments.
- **Every check:** par_done=1 for one cycle.
- **err_clr:** clears sticky and counter.
  - If a mismatch is registered in the same cycle, the error wins: sticky=1, counter=1.
- **Counter:** saturates at 2^CNT_WIDTH−1 and never wraps.
- bit_cnt width is $clog2(DATA_WIDTH+1).

## Timing
- **Reset:** RST low asynchronously forces state=IDLE, acc=0, bit_cnt=0, par_err=0, par_done=0, par_err_sticky=0, par_err_cnt=0.
- **Latency:** par_err and par_done assert in the cycle after the par_chk_en edge and last exactly one cycle. par_err_sticky and par_err_cnt update on that same edge.
- **Throughput:** a new frame_start is accepted in the cycle immediately after par_chk_en. Back-to-back frames need no idle gap.
- **Reset mid-frame:** the partial frame is discarded and no par_err or par_done is produced.
- **Simultaneous strobes:** data_vld and par_chk_en are never asserted together by the RX FSM. If they are, the strobe matching the current state is used and the other is ignored.

## Configuration
- PAR_ERR_CNT_EN:
  - Defined: par_err_cnt port and the saturating counter are built.
  - Undefined: the par_err_cnt port is absent and no counter logic is built. All other behaviour is identical.

## Test plan
- Even mode, DATA_WIDTH=8, bits of 0xA5, then parity 0 → par_done pulse, par_err=0. Same frame with parity 1 → par_err pulse, par_err_sticky=1.
- Odd mode, data 0x01, parity 0 → no error. Mark mode, any data, parity 0 → par_err. Space mode, parity 1 → par_err.
- DATA_WIDTH=5, mode latched as odd at frame_start, PAR_MODE switched to even mid-frame → check still uses odd.
- Counter (PAR_ERR_CNT_EN, CNT_WIDTH=2): 4 bad frames → par_err_cnt=3 (saturated). err_clr → 0. err_clr coincident with an error → par_err_cnt=1, sticky=1.
- Restart/reset: frame_start after 3 data bits → new frame of 8 bits checks correctly. RST low mid-DATA → all outputs 0, no par_done. par_chk_en in IDLE → ignored.
- Back-to-back: two frames with frame_start in the cycle right after the first par_chk_en → two par_done pulses, correct par_err for each.

Source files
------------

// File: rtl/uart_rx_parity_checker_seq.sv
// uart_rx_parity_checker_seq
//
// Serial parity checker for the UART receive path. Parity is accumulated one
// bit at a time as the RX sampler strobes data bits in, so the assembled
// parallel word is never needed. The received parity bit is then checked
// against the frame's latched parity mode. Results are a registered one-cycle
// error pulse, a one-cycle done pulse, a sticky error flag and, optionally,
// a saturating error counter.
//
// Optional feature macro: PAR_ERR_CNT_EN
//   defined   -> par_err_cnt port and saturating error counter are built
//   undefined -> no par_err_cnt port and no counter logic
//
// Ports:
//   CLK            in   system clock, rising edge
//   RST            in   asynchronous active-low reset
//   PAR_MODE[1:0]  in   00 even, 01 odd, 10 mark, 11 space (latched at frame_start)
//   frame_start    in   start-bit pulse; (re)starts a frame from any state
//   data_vld       in   sampled_bit is a data bit
//   par_chk_en     in   sampled_bit is the parity bit
//   sampled_bit    in   current sampled serial bit
//   err_clr        in   clears sticky flag and counter
//   par_err        out  one-cycle registered parity error pulse
//   par_done       out  one-cycle pulse per completed check
//   par_err_sticky out  set on any error, held until err_clr
//   par_err_cnt    out  saturating error count (PAR_ERR_CNT_EN only)

module uart_rx_parity_checker_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [1:0]           PAR_MODE,
    input  logic                 frame_start,
    input  logic                 data_vld,
    input  logic                 par_chk_en,
    input  logic                 sampled_bit,
    input  logic                 err_clr,
    output logic                 par_err,
    output logic                 par_done,
`ifdef PAR_ERR_CNT_EN
    output logic                 par_err_sticky,
    output logic [CNT_WIDTH-1:0] par_err_cnt
`else
    output logic                 par_err_sticky
`endif
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DATA     = 2'd1,
        WAIT_PAR = 2'd2
    } state_e;

    state_e        state_q;
    logic          acc_q;
    logic [BW-1:0] bit_cnt_q;
    logic [1:0]    mode_q;

    logic          exp_bit_d;
    logic          check_d;
    logic          mismatch_d;

    // Expected parity bit for the mode latched at the start of this frame.
    always_comb begin
        exp_bit_d = 1'b0;
        case (mode_q)
            2'b00:   exp_bit_d = acc_q;
            2'b01:   exp_bit_d = ~acc_q;
            2'b10:   exp_bit_d = 1'b1;
            default: exp_bit_d = 1'b0;
        endcase
    end

    // frame_start outranks a coincident parity strobe: the old frame is dropped.
    assign check_d    = (state_q == WAIT_PAR) && par_chk_en && !frame_start;
    assign mismatch_d = check_d && (sampled_bit != exp_bit_d);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q        <= IDLE;
            acc_q          <= 1'b0;
            bit_cnt_q      <= '0;
            mode_q         <= 2'b00;
            par_err        <= 1'b0;
            par_done       <= 1'b0;
            par_err_sticky <= 1'b0;
        end else begin
            par_err  <= mismatch_d;
            par_done <= check_d;

            if (frame_start) begin
                state_q   <= DATA;
                acc_q     <= 1'b0;
                bit_cnt_q <= '0;
                mode_q    <= PAR_MODE;
            end else begin
                case (state_q)
                    DATA: begin
                        if (data_vld) begin
                            acc_q     <= acc_q ^ sampled_bit;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == LAST_BIT) state_q <= WAIT_PAR;
                        end
                    end
                    WAIT_PAR: begin
                        if (par_chk_en) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end

            // A new error in the same cycle beats err_clr.
            if (mismatch_d)   par_err_sticky <= 1'b1;
            else if (err_clr) par_err_sticky <= 1'b0;
        end
    end

`ifdef PAR_ERR_CNT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_err_cnt <= '0;
        end else if (mismatch_d) begin
            if (err_clr)               par_err_cnt <= CNT_WIDTH'(1);
            else if (par_err_cnt != '1) par_err_cnt <= par_err_cnt + 1'b1;
        end else if (err_clr) begin
            par_err_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_parity_checker_seq.sv
// Scoreboard bench for uart_rx_parity_checker_seq. Two instances: index 0 has
// DATA_WIDTH=8 (CNT_WIDTH=2 so saturation is reachable), index 1 has
// DATA_WIDTH=5. Frame stimulus pushes the hand-computed expected par_err into
// a per-instance queue; a monitor pops on every par_done.
module tb_uart_rx_parity_checker_seq;

    localparam logic [1:0] EVEN = 2'b00, ODD = 2'b01, MARK = 2'b10, SPACE = 2'b11;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    logic [1:0][1:0] pm = '0;
    logic [1:0] fs = '0, dv = '0, pc = '0, sb = '0, ec = '0;
    logic pe0, pd0, st0, pe1, pd1, st1;
`ifdef PAR_ERR_CNT_EN
    logic [1:0] cnt0;
    logic [7:0] cnt1;
`endif

    int checks = 0;
    int errors = 0;
    bit q0[$];
    bit q1[$];

    uart_rx_parity_checker_seq #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut8 (
        .CLK(CLK), .RST(RST), .PAR_MODE(pm[0]), .frame_start(fs[0]),
        .data_vld(dv[0]), .par_chk_en(pc[0]), .sampled_bit(sb[0]), .err_clr(ec[0]),
        .par_err(pe0), .par_done(pd0),
`ifdef PAR_ERR_CNT_EN
        .par_err_sticky(st0), .par_err_cnt(cnt0)
`else
        .par_err_sticky(st0)
`endif
    );

    uart_rx_parity_checker_seq #(.DATA_WIDTH(5), .CNT_WIDTH(8)) dut5 (
        .CLK(CLK), .RST(RST), .PAR_MODE(pm[1]), .frame_start(fs[1]),
        .data_vld(dv[1]), .par_chk_en(pc[1]), .sampled_bit(sb[1]), .err_clr(ec[1]),
        .par_err(pe1), .par_done(pd1),
`ifdef PAR_ERR_CNT_EN
        .par_err_sticky(st1), .par_err_cnt(cnt1)
`else
        .par_err_sticky(st1)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Full frame: start, n data bits (LSB first), parity bit. mode_mid is
    // driven on PAR_MODE after the first data bit to prove the mode is latched.
    task automatic frame(input int idx, input logic [1:0] mode, input logic [1:0] mode_mid,
                         input logic [8:0] data, input int n, input logic par,
                         input bit exp_err, input logic clr);
        fs[idx] = 1'b1;
        pm[idx] = mode;
        tick();
        fs[idx] = 1'b0;
        for (int i = 0; i < n; i++) begin
            dv[idx] = 1'b1;
            sb[idx] = data[i];
            tick();
            pm[idx] = mode_mid;
        end
        dv[idx] = 1'b0;
        pc[idx] = 1'b1;
        sb[idx] = par;
        ec[idx] = clr;
        if (idx == 0) q0.push_back(exp_err);
        else          q1.push_back(exp_err);
        tick();
        pc[idx] = 1'b0;
        ec[idx] = 1'b0;
    endtask

    task automatic partial(input int idx, input int n);
        fs[idx] = 1'b1;
        pm[idx] = EVEN;
        tick();
        fs[idx] = 1'b0;
        for (int i = 0; i < n; i++) begin
            dv[idx] = 1'b1;
            sb[idx] = 1'b1;
            tick();
        end
        dv[idx] = 1'b0;
    endtask

    task automatic clear(input int idx);
        ec[idx] = 1'b1;
        tick();
        ec[idx] = 1'b0;
    endtask

    // Monitor: every par_done consumes one expected result.
    always @(negedge CLK) begin
        if (pd0) begin
            if (q0.size() == 0) chk("dut8 unexpected par_done", 1, 0);
            else chk("dut8 par_err", 32'(pe0), 32'(q0.pop_front()));
        end else if (pe0) begin
            chk("dut8 par_err without par_done", 1, 0);
        end
        if (pd1) begin
            if (q1.size() == 0) chk("dut5 unexpected par_done", 1, 0);
            else chk("dut5 par_err", 32'(pe1), 32'(q1.pop_front()));
        end else if (pe1) begin
            chk("dut5 par_err without par_done", 1, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        chk("reset par_err", 32'(pe0), 0);
        chk("reset par_done", 32'(pd0), 0);
        chk("reset sticky", 32'(st0), 0);
`ifdef PAR_ERR_CNT_EN
        chk("reset cnt", 32'(cnt0), 0);
`endif
        repeat (2) tick();
        RST = 1'b1;
        tick();

        // Even, 0xA5 has four ones: parity 0 good, 1 bad.
        frame(0, EVEN, EVEN, 9'h0A5, 8, 1'b0, 1'b0, 1'b0);
        chk("sticky after good frame", 32'(st0), 0);
        frame(0, EVEN, EVEN, 9'h0A5, 8, 1'b1, 1'b1, 1'b0);
        chk("sticky after bad frame", 32'(st0), 1);
        clear(0);
        chk("sticky after err_clr", 32'(st0), 0);

        frame(0, ODD,   ODD,   9'h001, 8, 1'b0, 1'b0, 1'b0);
        frame(0, ODD,   ODD,   9'h0A5, 8, 1'b0, 1'b1, 1'b0);
        frame(0, MARK,  MARK,  9'h03C, 8, 1'b0, 1'b1, 1'b0);
        frame(0, MARK,  MARK,  9'h03C, 8, 1'b1, 1'b0, 1'b0);
        frame(0, SPACE, SPACE, 9'h0FF, 8, 1'b1, 1'b1, 1'b0);
        frame(0, SPACE, SPACE, 9'h0FF, 8, 1'b0, 1'b0, 1'b0);

        // 5-bit frame 10110 (three ones): odd expects 0; PAR_MODE flips to even mid-frame.
        frame(1, ODD, EVEN, 9'h016, 5, 1'b0, 1'b0, 1'b0);
        frame(1, ODD, EVEN, 9'h016, 5, 1'b1, 1'b1, 1'b0);
        chk("dut5 sticky", 32'(st1), 1);

        // Restart after 3 data bits, then a clean 8-bit frame.
        clear(0);
        partial(0, 3);
        frame(0, EVEN, EVEN, 9'h0A5, 8, 1'b0, 1'b0, 1'b0);
        chk("sticky after restart frame", 32'(st0), 0);

        // Back-to-back frames, no idle gap.
        frame(0, EVEN, EVEN, 9'h0A5, 8, 1'b1, 1'b1, 1'b0);
        frame(0, ODD,  ODD,  9'h001, 8, 1'b0, 1'b0, 1'b0);

`ifdef PAR_ERR_CNT_EN
        clear(0);
        chk("cnt after clear", 32'(cnt0), 0);
        for (int i = 0; i < 4; i++) frame(0, MARK, MARK, 9'h000, 8, 1'b0, 1'b1, 1'b0);
        chk("cnt saturated", 32'(cnt0), 3);
        clear(0);
        chk("cnt after err_clr", 32'(cnt0), 0);
        chk("sticky after err_clr 2", 32'(st0), 0);
        frame(0, MARK, MARK, 9'h000, 8, 1'b0, 1'b1, 1'b1);
        chk("cnt err_clr+error", 32'(cnt0), 1);
        chk("sticky err_clr+error", 32'(st0), 1);
`else
        frame(0, MARK, MARK, 9'h000, 8, 1'b0, 1'b1, 1'b0);
`endif

        // Reset in the middle of the data bits: everything clears, no done.
        partial(0, 4);
        RST = 1'b0;
        #1;
        chk("midreset par_err", 32'(pe0), 0);
        chk("midreset par_done", 32'(pd0), 0);
        chk("midreset sticky", 32'(st0), 0);
`ifdef PAR_ERR_CNT_EN
        chk("midreset cnt", 32'(cnt0), 0);
`endif
        tick();
        RST = 1'b1;
        tick();
        // Parity strobe while idle must be ignored.
        pc[0] = 1'b1;
        sb[0] = 1'b1;
        tick();
        pc[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("idle par_chk_en par_done", 32'(pd0), 0);
            tick();
        end

        repeat (3) tick();
        chk("dut8 pending results", q0.size(), 0);
        chk("dut5 pending results", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
